// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and helpers for the sync_fifo block.
//   clog2()          - ceiling log2, usable in parameter/localparam expressions
//   DEF_*            - default parameter values for the FIFO and its flags
package sync_fifo_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_AE_THRESH = 4;
    // almost_full default sits this many entries below DEPTH
    localparam int DEF_AF_MARGIN = 4;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bus of sync_fifo.
//   master modport - the user side: drives flush/wr_en/wr_data/rd_en,
//                    observes data, occupancy and flags
//   slave modport  - the FIFO side
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int ADDR = clog2(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: WIDTH x DEPTH storage for sync_fifo.
//   clk, rst_n   - clock, async active-low reset (read register only)
//   i_wr_en/i_wr_addr/i_wr_data - synchronous write port
//   i_rd_en/i_rd_addr           - read port
//   o_rd_data    - registered read data (FWFT=0, loads on i_rd_en, resets to 0)
//                  or asynchronous read of i_rd_addr (FWFT=1)
// The array itself is never reset.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter bit FWFT  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_wr_en,
    input  logic [clog2(DEPTH)-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    input  logic [clog2(DEPTH)-1:0]    i_rd_addr,
    output logic [WIDTH-1:0]           o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Read enable and reset have no role with an asynchronous read.
            logic w_unused;
            assign w_unused  = ^{i_rd_en, rst_n};
            assign o_rd_data = r_mem[i_rd_addr];
        end else begin : g_std
            logic [WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data <= '0;
                end else if (i_rd_en) begin
                    r_rd_data <= r_mem[i_rd_addr];
                end
            end
            assign o_rd_data = r_rd_data;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy count,
// full/empty, programmable almost-full/almost-empty, sticky overflow/underflow,
// synchronous flush and optional first-word-fall-through read.
//   clk    - clock, all logic on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - sync_fifo_if.slave: flush, wr_en, wr_data, rd_en in;
//            rd_data, full, empty, almost_full, almost_empty, count,
//            overflow, underflow out
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter bit FWFT      = 1'b0,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);

    localparam int ADDR = clog2(DEPTH);

    localparam logic [ADDR:0] FULL_LVL = DEPTH[ADDR:0];
    localparam logic [ADDR:0] AF_LVL   = AF_THRESH[ADDR:0];
    localparam logic [ADDR:0] AE_LVL   = AE_THRESH[ADDR:0];

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [ADDR:0]   r_count;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_wacc;
    logic            w_racc;

    // Flags come only from the registered count, never from this cycle's requests.
    assign w_full  = (r_count == FULL_LVL);
    assign w_empty = (r_count == '0);

    // flush suppresses both requests so neither memory nor pointers move.
    assign w_wacc = bus.wr_en && !w_full  && !bus.flush;
    assign w_racc = bus.rd_en && !w_empty && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wacc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_racc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wacc, w_racc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FWFT  (FWFT)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wacc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_en   (w_racc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (bus.rd_data)
    );

    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_LVL);
    assign bus.almost_empty = (r_count <= AE_LVL);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a standard-mode and an FWFT-mode sync_fifo (both
// DEPTH=8, WIDTH=8) with identical request streams and compares them against
// a queue-based reference model.
module tb_sync_fifo;

    localparam int W = 8;
    localparam int D = 8;

    logic clk;
    logic rst_n;

    sync_fifo_if #(.WIDTH(W), .DEPTH(D)) s_if ();
    sync_fifo_if #(.WIDTH(W), .DEPTH(D)) f_if ();

    sync_fifo #(
        .WIDTH     (W),
        .DEPTH     (D),
        .FWFT      (1'b0),
        .AF_THRESH (4),
        .AE_THRESH (2)
    ) u_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if)
    );

    sync_fifo #(
        .WIDTH     (W),
        .DEPTH     (D),
        .FWFT      (1'b1),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) u_fwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents, sticky errors, standard-mode output register.
    logic [W-1:0] q[$];
    bit           m_ovf;
    bit           m_unf;
    logic [W-1:0] m_rd;

    // Observed status vectors {full, empty, af, ae, ovf, unf, count}.
    logic [9:0] s_stat;
    logic [9:0] f_stat;
    assign s_stat = {s_if.full, s_if.empty, s_if.almost_full, s_if.almost_empty,
                     s_if.overflow, s_if.underflow, s_if.count};
    assign f_stat = {f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty,
                     f_if.overflow, f_if.underflow, f_if.count};

    function automatic logic [9:0] exp_status(input int af, input int ae);
        int n;
        n = q.size();
        return {n == D, n == 0, n >= af, n <= ae, m_ovf, m_unf, 4'(n)};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd  = '0;
    endfunction

    // One clock of requests to both FIFOs; model advances after the edge.
    task automatic cycle(input bit f, input bit w, input logic [W-1:0] d, input bit r);
        int n;
        bit wa;
        bit ra;
        s_if.flush = f; s_if.wr_en = w; s_if.wr_data = d; s_if.rd_en = r;
        f_if.flush = f; f_if.wr_en = w; f_if.wr_data = d; f_if.rd_en = r;
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            n  = q.size();
            wa = w && (n < D);
            ra = r && (n > 0);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) m_rd = q.pop_front();
            if (wa) q.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_if.flush = 0; s_if.wr_en = 0; s_if.wr_data = '0; s_if.rd_en = 0;
        f_if.flush = 0; f_if.wr_en = 0; f_if.wr_data = '0; f_if.rd_en = 0;
        model_reset();
        #1;
        checks++;
        if (s_stat !== exp_status(4, 2)) begin
            failures++;
            $display("FAIL reset_std_status got=%b want=%b", s_stat, exp_status(4, 2));
        end
        checks++;
        if (f_stat !== exp_status(6, 1)) begin
            failures++;
            $display("FAIL reset_fwft_status got=%b want=%b", f_stat, exp_status(6, 1));
        end
        checks++;
        if (s_if.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_std_rd_data got=%h want=00", s_if.rd_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 8'(8'h11 + i), 1'b0);
            checks++;
            if (s_stat !== exp_status(4, 2)) begin
                failures++;
                $display("FAIL fill_std_status[%0d] got=%b want=%b", i, s_stat, exp_status(4, 2));
            end
            checks++;
            if (f_stat !== exp_status(6, 1)) begin
                failures++;
                $display("FAIL fill_fwft_status[%0d] got=%b want=%b", i, f_stat, exp_status(6, 1));
            end
        end
        checks++;
        if (s_if.full !== 1'b1 || s_if.overflow !== 1'b1 || s_if.count !== 4'd8) begin
            failures++;
            $display("FAIL fill_overflow_final full=%b ovf=%b count=%0d want 1 1 8",
                     s_if.full, s_if.overflow, s_if.count);
        end
        checks++;
        if (f_if.rd_data !== 8'h11) begin
            failures++;
            $display("FAIL fill_fwft_head got=%h want=11", f_if.rd_data);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
                failures++;
                $display("FAIL drain_std[%0d] got=%b/%h want=%b/%h", i, s_stat, s_if.rd_data,
                         exp_status(4, 2), m_rd);
            end
            checks++;
            if (f_stat !== exp_status(6, 1)) begin
                failures++;
                $display("FAIL drain_fwft_status[%0d] got=%b want=%b", i, f_stat, exp_status(6, 1));
            end
        end
        checks++;
        if (s_if.rd_data !== 8'h18 || s_if.underflow !== 1'b1 || s_if.empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_final rd=%h unf=%b empty=%b want 18 1 1",
                     s_if.rd_data, s_if.underflow, s_if.empty);
        end
    endtask

    task automatic test_wrap();
        int lens[2] = '{6, 5};
        foreach (lens[k]) begin
            for (int i = 0; i < lens[k]; i++) begin
                cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
            end
            for (int i = 0; i < lens[k]; i++) begin
                if (q.size() > 0) begin
                    checks++;
                    if (f_if.rd_data !== q[0]) begin
                        failures++;
                        $display("FAIL wrap_fwft_data got=%h want=%h", f_if.rd_data, q[0]);
                    end
                end
                cycle(1'b0, 1'b0, '0, 1'b1);
                checks++;
                if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
                    failures++;
                    $display("FAIL wrap_std got=%b/%h want=%b/%h", s_stat, s_if.rd_data,
                             exp_status(4, 2), m_rd);
                end
            end
        end
        checks++;
        if (s_if.count !== 4'd0 || f_if.count !== 4'd0) begin
            failures++;
            $display("FAIL wrap_final_count std=%0d fwft=%0d want=0", s_if.count, f_if.count);
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
            checks++;
            if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
                failures++;
                $display("FAIL simul_cnt3[%0d] got=%b/%h want=%b/%h", i, s_stat, s_if.rd_data,
                         exp_status(4, 2), m_rd);
            end
        end
        // At full: read only, overflow raised.
        while (q.size() < D) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        checks++;
        if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
            failures++;
            $display("FAIL simul_full got=%b/%h want=%b/%h", s_stat, s_if.rd_data,
                     exp_status(4, 2), m_rd);
        end
        // At empty: write only, underflow raised.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 8'h5C, 1'b1);
        checks++;
        if ({s_stat, f_stat} !== {exp_status(4, 2), exp_status(6, 1)}) begin
            failures++;
            $display("FAIL simul_empty got=%b/%b want=%b/%b", s_stat, f_stat,
                     exp_status(4, 2), exp_status(6, 1));
        end
        checks++;
        if (f_if.rd_data !== 8'h5C) begin
            failures++;
            $display("FAIL simul_empty_fwft_data got=%h want=5c", f_if.rd_data);
        end
    endtask

    task automatic test_fwft();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 8'hA5, 1'b0);
        checks++;
        if (f_if.rd_data !== 8'hA5 || f_if.empty !== 1'b0) begin
            failures++;
            $display("FAIL fwft_first rd=%h empty=%b want a5 0", f_if.rd_data, f_if.empty);
        end
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (f_if.empty !== 1'b1 || f_if.underflow !== 1'b0) begin
            failures++;
            $display("FAIL fwft_pop empty=%b unf=%b want 1 0", f_if.empty, f_if.underflow);
        end
    endtask

    task automatic test_flush();
        while (q.size() < D) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (s_if.count !== 4'd5 || s_if.overflow !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup count=%0d ovf=%b want 5 1", s_if.count, s_if.overflow);
        end
        cycle(1'b1, 1'b1, 8'h99, 1'b0);
        checks++;
        if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
            failures++;
            $display("FAIL flush_std got=%b/%h want=%b/%h", s_stat, s_if.rd_data,
                     exp_status(4, 2), m_rd);
        end
        checks++;
        if (f_stat !== exp_status(6, 1)) begin
            failures++;
            $display("FAIL flush_fwft got=%b want=%b", f_stat, exp_status(6, 1));
        end
    endtask

    task automatic test_random();
        int bias;
        for (int i = 0; i < 400; i++) begin
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            if (q.size() > 0) begin
                checks++;
                if (f_if.rd_data !== q[0]) begin
                    failures++;
                    $display("FAIL rand_fwft_data[%0d] got=%h want=%h", i, f_if.rd_data, q[0]);
                end
            end
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 99) < bias,
                  8'($urandom), $urandom_range(0, 99) >= bias);
            checks++;
            if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
                failures++;
                $display("FAIL rand_std[%0d] got=%b/%h want=%b/%h", i, s_stat, s_if.rd_data,
                         exp_status(4, 2), m_rd);
            end
            checks++;
            if (f_stat !== exp_status(6, 1)) begin
                failures++;
                $display("FAIL rand_fwft_status[%0d] got=%b want=%b", i, f_stat, exp_status(6, 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        // Assert reset between edges with requests still pending.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), m_rd}) begin
            failures++;
            $display("FAIL reset_mid_std got=%b/%h want=%b/%h", s_stat, s_if.rd_data,
                     exp_status(4, 2), m_rd);
        end
        checks++;
        if (f_stat !== exp_status(6, 1)) begin
            failures++;
            $display("FAIL reset_mid_fwft got=%b want=%b", f_stat, exp_status(6, 1));
        end
        s_if.wr_en = 0; s_if.rd_en = 0;
        f_if.wr_en = 0; f_if.rd_en = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 8'h42, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if ({s_stat, s_if.rd_data} !== {exp_status(4, 2), 8'h42}) begin
            failures++;
            $display("FAIL reset_mid_recover got=%b/%h want=%b/42", s_stat, s_if.rd_data,
                     exp_status(4, 2));
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_flush();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
